// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial a - b, one difference bit per clock, LSB first,
//                through a single registered full-subtractor stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_diff_sh;
    logic [WIDTH-1:0]   r_diff;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_bin;
    logic               r_borrow;
    logic               r_busy;
    logic               r_done;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_bnext;
    logic [WIDTH-1:0]   w_diff_next;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    assign w_x         = r_a_sh[0];
    assign w_y         = r_b_sh[0];
    assign w_d         = w_x ^ w_y ^ r_bin;
    assign w_bnext     = (~w_x & w_y) | (~(w_x ^ w_y) & r_bin);
    assign w_diff_next = {w_d, r_diff_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_diff    <= '0;
            r_cnt     <= '0;
            r_bin     <= 1'b0;
            r_borrow  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_bin     <= w_bnext;
                    r_diff_sh <= w_diff_next;
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt     <= r_cnt + c_cnt_w'(1);
                    // Result registers change only here, so outputs never show a partial value.
                    if (r_cnt == c_last) begin
                        r_diff   <= w_diff_next;
                        r_borrow <= w_bnext;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Scoreboard bench for serial_subtractor with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    logic [W:0]   exp_q[$];
    int           n_cmp;
    int           n_bad;
    int           done_cnt;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got diff=%h borrow=%0d, required no done", diff, borrow_out);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({borrow_out, diff} !== e) begin
                    n_bad++;
                    $display("FAIL result: got diff=%h borrow=%0d, required diff=%h borrow=%0d",
                             diff, borrow_out, e[W-1:0], e[W]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns after the next negedge with start low.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input bit push);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) exp_q.push_back({eb, ed});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles (negedges) since acceptance; first call sits at k=1.
    task automatic wait_done(output int k, output int busy_cycles);
        k = 1;
        busy_cycles = 0;
        while (!done && k < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done after %0d cycles, required done", k);
        end
    endtask

    int k;
    int bc;
    int dc0;

    initial begin
        n_cmp = 0; n_bad = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic with latency and busy-length checks
        launch(8'd5, 8'd3, 8'h02, 1'b0, 1'b1);
        wait_done(k, bc);
        check("basic_latency", k, W + 1);
        check("basic_busy_cycles", bc, W);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("hold_diff", diff, 8'h02);
        check("hold_busy", busy, 0);

        launch(8'd3, 8'd5, 8'hFE, 1'b1, 1'b1);
        wait_done(k, bc); @(negedge clk);
        launch(8'h00, 8'hFF, 8'h01, 1'b1, 1'b1);
        wait_done(k, bc); @(negedge clk);
        launch(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        wait_done(k, bc); @(negedge clk);
        launch(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b1);
        wait_done(k, bc); @(negedge clk);
        launch(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        wait_done(k, bc); @(negedge clk);

        // Start during RUN must be ignored
        dc0 = done_cnt;
        launch(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bc);
        repeat (12) @(negedge clk);
        check("ignored_start_done_count", done_cnt - dc0, 1);

        // Back-to-back: new start presented in the done cycle
        launch(8'h07, 8'h03, 8'h04, 1'b0, 1'b1);
        wait_done(k, bc);
        launch(8'h01, 8'h02, 8'hFF, 1'b1, 1'b1);
        check("b2b_busy_next", busy, 1);
        wait_done(k, bc);
        check("b2b_latency", k, W + 1);
        @(negedge clk);

        // Reset four cycles into RUN aborts without a done
        dc0 = done_cnt;
        launch(8'h33, 8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow_out, 0);
        repeat (12) @(negedge clk);
        check("midrst_no_done", done_cnt - dc0, 0);

        launch(8'd7, 8'd2, 8'h05, 1'b0, 1'b1);
        wait_done(k, bc);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial full-subtractor engine: the inverse-direction companion to the team's combinational full-adder cell. It accepts two WIDTH-bit unsigned operands through a start/busy/done handshake and computes one difference bit per clock, LSB first, through a single registered full-subtractor stage. The result is `a - b` modulo 2^WIDTH plus a borrow-out flag. It sits behind the chip's dedicated-input pins as an arithmetic peripheral beside the adder.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Legal range is WIDTH ≥ 2.

Ports:
- `clk` input, 1: the single clock. All state updates on its rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `start` input, 1: request to begin a subtraction. Sampled only while `busy`=0.
- `a` input, WIDTH: minuend, captured on the accepted `start` edge.
- `b` input, WIDTH: subtrahend, captured on the accepted `start` edge.
- `busy` output, 1: high while a subtraction is in progress.
- `done` output, 1: one-cycle pulse marking that `diff` and `borrow_out` are valid.
- `diff` output, WIDTH: result, `(a - b) mod 2^WIDTH`.
- `borrow_out` output, 1: set to 1 iff `a < b` (unsigned comparison).

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - `a_sh` and `b_sh`: operand shift registers.
  - `bin`: borrow flop.
  - `cnt`: bit counter, $clog2(WIDTH)+1 bits.
  - `diff_sh`: result shift register.
- IDLE or DONE with `start`=1:
  - Load `a_sh`←`a`, `b_sh`←`b`, `bin`←0, `cnt`←0.
  - Move to RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- RUN, each edge, with x=`a_sh[0]` and y=`b_sh[0]`:
  - d = x^y^`bin`.
  - `bin` ← (~x&y) | (~(x^y)&`bin`).
  - `diff_sh` ← {d, `diff_sh[WIDTH-1:1]`} (shift right, new bit enters at the MSB).
  - `a_sh` and `b_sh` shift right by one.
  - `cnt` increments.
  - When `cnt`==WIDTH-1 this edge processes the last bit, latches the final borrow into `borrow_out`, and moves to DONE.
- `start` while in RUN is ignored; operands are not re-captured.
- `diff` and `borrow_out` hold their last result through IDLE until the next completion. Outputs are never partially updated; `diff` is driven from a result register updated only on the finishing edge.
- `busy` = (state==RUN). `done` = (state==DONE).

## Timing
- Reset, synchronous: on any edge with `rst`=1 the block goes to IDLE, and all registers and outputs clear.
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
  - Reset mid-RUN aborts the operation and no `done` is produced.
  - `rst` has priority over `start`.
- Latency, with `start` accepted at edge E0:
  - `busy`=1 from after E0 through E(WIDTH).
  - Bit i is computed at edge E(i+1).
  - `done`=1 and the result is valid for exactly one cycle, after E(WIDTH).
  - Start-to-done is WIDTH+1 cycles.
- Back-to-back operation: `start`=1 during the DONE cycle is accepted at E(WIDTH+1). `busy` rises immediately with no idle gap, so throughput is one result per WIDTH+1 cycles.
- `a` and `b` need to be stable only at the accepting edge.

## Test plan
- Basic: reset, then `a`=5, `b`=3, `start` for 1 cycle → `busy` for 8 cycles, then `done` pulse with `diff`=0x02, `borrow_out`=0. `done` rises exactly 9 cycles after the start edge.
- Borrow: `a`=3, `b`=5 → `diff`=0xFE, `borrow_out`=1. Separately, `a`=0x00, `b`=0xFF → `diff`=0x01, `borrow_out`=1.
- Edge values: 0x00-0x00 → `diff`=0x00, `borrow_out`=0. 0xFF-0x00 → `diff`=0xFF, `borrow_out`=0. 0x80-0x01 → `diff`=0x7F, `borrow_out`=0.
- Ignored start: during RUN of 0x10-0x01, pulse `start` with `a`=0xAA, `b`=0x55 → result stays 0x0F, `borrow_out`=0, and only one `done` pulse occurs.
- Back-to-back: assert `start` in the `done` cycle with 0x01-0x02 → `busy` high the next cycle, second `done` 9 cycles later with `diff`=0xFF, `borrow_out`=1.
- Reset mid-op: assert `rst` 4 cycles into RUN → next cycle `busy`=0, `diff`=0, `borrow_out`=0, and no `done` afterwards. Then a fresh 7-2 → `diff`=0x05.
